// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter that time-shares one combinational ALU
// between two valid/ready requesters. One operation is in flight at a time;
// the ALU result is captured into a register and returned on the owner's
// response channel.
module alu_share_arb #(
    parameter int BITS  = 32,
    parameter int CBITS = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [BITS-1:0]  REQ0_A,
    input  logic [BITS-1:0]  REQ0_B,
    input  logic [CBITS-1:0] REQ0_CTL,
    output logic             RSP0_VALID,
    input  logic             RSP0_READY,
    output logic [BITS-1:0]  RSP0_OUT,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [BITS-1:0]  REQ1_A,
    input  logic [BITS-1:0]  REQ1_B,
    input  logic [CBITS-1:0] REQ1_CTL,
    output logic             RSP1_VALID,
    input  logic             RSP1_READY,
    output logic [BITS-1:0]  RSP1_OUT,
    output logic [BITS-1:0]  ALU_A,
    output logic [BITS-1:0]  ALU_B,
    output logic [CBITS-1:0] ALU_CTL,
    input  logic [BITS-1:0]  ALU_OUT,
    output logic             BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic            owner_reg, owner_next;
    logic            last_reg,  last_next;
    logic [BITS-1:0] res_reg,   res_next;

    // Grant candidate: a lone requester wins; on a tie the one not served last wins.
    logic grant_valid;
    logic grant_sel;
    assign grant_valid = REQ0_VALID | REQ1_VALID;
    assign grant_sel   = (REQ0_VALID & REQ1_VALID) ? ~last_reg : REQ1_VALID;

    // The held result is presented on both response ports; only the owner's VALID rises.
    assign RSP0_OUT = res_reg;
    assign RSP1_OUT = res_reg;
    assign BUSY     = (state_reg == RESP);

    // Next-state, grant/ready, ALU operand steering and response handshake.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        res_next   = res_reg;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        RSP0_VALID = 1'b0;
        RSP1_VALID = 1'b0;
        ALU_A      = '0;
        ALU_B      = '0;
        ALU_CTL    = '0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    // Granted requester is VALID by construction, so grant == accept.
                    if (grant_sel) begin
                        REQ1_READY = 1'b1;
                        ALU_A      = REQ1_A;
                        ALU_B      = REQ1_B;
                        ALU_CTL    = REQ1_CTL;
                    end else begin
                        REQ0_READY = 1'b1;
                        ALU_A      = REQ0_A;
                        ALU_B      = REQ0_B;
                        ALU_CTL    = REQ0_CTL;
                    end
                    res_next   = ALU_OUT;
                    owner_next = grant_sel;
                    last_next  = grant_sel;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (owner_reg) begin
                    RSP1_VALID = 1'b1;
                    if (RSP1_READY) state_next = IDLE;
                end else begin
                    RSP0_VALID = 1'b1;
                    if (RSP0_READY) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and result registers; reset drops any held result and favours requester 0.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            res_reg   <= res_next;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: directed steps with a scoreboard of expected
// results pushed on accept and popped on response handshake.
module tb_alu_share_arb;

    localparam int BITS  = 32;
    localparam int CBITS = 5;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             REQ0_VALID, REQ0_READY, RSP0_VALID, RSP0_READY;
    logic [BITS-1:0]  REQ0_A, REQ0_B, RSP0_OUT;
    logic [CBITS-1:0] REQ0_CTL;
    logic             REQ1_VALID, REQ1_READY, RSP1_VALID, RSP1_READY;
    logic [BITS-1:0]  REQ1_A, REQ1_B, RSP1_OUT;
    logic [CBITS-1:0] REQ1_CTL;
    logic [BITS-1:0]  ALU_A, ALU_B, ALU_OUT;
    logic [CBITS-1:0] ALU_CTL;
    logic             BUSY;

    always #5 CLK = ~CLK;

    // Bench ALU: ADD=0, SUB=1, anything else undefined.
    assign ALU_OUT = (ALU_CTL == 5'd0) ? ALU_A + ALU_B :
                     (ALU_CTL == 5'd1) ? ALU_A - ALU_B : 'x;

    alu_share_arb #(.BITS(BITS), .CBITS(CBITS)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A),
        .REQ0_B(REQ0_B), .REQ0_CTL(REQ0_CTL), .RSP0_VALID(RSP0_VALID),
        .RSP0_READY(RSP0_READY), .RSP0_OUT(RSP0_OUT),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A),
        .REQ1_B(REQ1_B), .REQ1_CTL(REQ1_CTL), .RSP1_VALID(RSP1_VALID),
        .RSP1_READY(RSP1_READY), .RSP1_OUT(RSP1_OUT),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CTL(ALU_CTL), .ALU_OUT(ALU_OUT),
        .BUSY(BUSY)
    );

    typedef struct {
        logic            who;
        logic [BITS-1:0] res;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    logic      grant_log[$];
    int        tests  = 0;
    int        failed = 0;

    // Reference behaviour of the arbiter, advanced once per clock.
    logic m_busy  = 1'b0;
    logic m_owner = 1'b0;
    logic m_last  = 1'b1;
    logic acc0, acc1;

    function automatic logic [BITS-1:0] alu_model(logic [BITS-1:0] a, logic [BITS-1:0] b,
                                                  logic [CBITS-1:0] c);
        return (c == 5'd0) ? a + b : a - b;
    endfunction

    task automatic chk(string tag, logic [BITS-1:0] obs, logic [BITS-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic tick();
        logic      e_r0, e_r1, rsp_take;
        sb_entry_t e;
        @(negedge CLK);
        acc0 = 1'b0;
        acc1 = 1'b0;
        rsp_take = 1'b0;
        e_r0 = !m_busy && REQ0_VALID && (!REQ1_VALID || m_last == 1'b1);
        e_r1 = !m_busy && REQ1_VALID && (!REQ0_VALID || m_last == 1'b0);
        chk("req0_ready", {31'd0, REQ0_READY}, {31'd0, e_r0});
        chk("req1_ready", {31'd0, REQ1_READY}, {31'd0, e_r1});
        chk("busy", {31'd0, BUSY}, {31'd0, m_busy});
        chk("rsp0_valid", {31'd0, RSP0_VALID}, {31'd0, m_busy && !m_owner});
        chk("rsp1_valid", {31'd0, RSP1_VALID}, {31'd0, m_busy && m_owner});
        chk("alu_a", ALU_A, e_r0 ? REQ0_A : e_r1 ? REQ1_A : '0);
        chk("alu_b", ALU_B, e_r0 ? REQ0_B : e_r1 ? REQ1_B : '0);
        chk("alu_ctl", {27'd0, ALU_CTL}, {27'd0, e_r0 ? REQ0_CTL : e_r1 ? REQ1_CTL : 5'd0});
        if (m_busy) begin
            chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                chk("rsp0_out", RSP0_OUT, sb_q[0].res);
                chk("rsp1_out", RSP1_OUT, sb_q[0].res);
                rsp_take = m_owner ? RSP1_READY : RSP0_READY;
                if (rsp_take) begin
                    e = sb_q.pop_front();
                    chk("rsp_owner", {31'd0, m_owner}, {31'd0, e.who});
                    $display("[TB] rsp  port%0d out=0x%08h exp=0x%08h", m_owner,
                             m_owner ? RSP1_OUT : RSP0_OUT, e.res);
                end
            end
        end
        if (e_r0) begin
            sb_q.push_back('{1'b0, alu_model(REQ0_A, REQ0_B, REQ0_CTL)});
            $display("[TB] req  port0 a=0x%08h b=0x%08h ctl=%0d", REQ0_A, REQ0_B, REQ0_CTL);
        end else if (e_r1) begin
            sb_q.push_back('{1'b1, alu_model(REQ1_A, REQ1_B, REQ1_CTL)});
            $display("[TB] req  port1 a=0x%08h b=0x%08h ctl=%0d", REQ1_A, REQ1_B, REQ1_CTL);
        end
        @(posedge CLK);
        if (e_r0 || e_r1) begin
            m_busy  = 1'b1;
            m_owner = e_r1;
            m_last  = e_r1;
            grant_log.push_back(e_r1);
            acc0 = e_r0;
            acc1 = e_r1;
        end else if (m_busy && rsp_take) begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    // One clock with reset asserted; the model and scoreboard are cleared.
    task automatic reset_tick();
        RESET_N = 1'b0;
        @(posedge CLK);
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        sb_q.delete();
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N = 1'b0;
        REQ0_VALID = 0; REQ0_A = 0; REQ0_B = 0; REQ0_CTL = 0; RSP0_READY = 0;
        REQ1_VALID = 0; REQ1_A = 0; REQ1_B = 0; REQ1_CTL = 0; RSP1_READY = 0;

        // Reset, then check quiescent outputs.
        reset_tick();
        reset_tick();
        tick();

        // Single ADD: 5 + 7 = 12 on port 0.
        REQ0_A = 32'd5; REQ0_B = 32'd7; REQ0_CTL = 5'd0; REQ0_VALID = 1; RSP0_READY = 1;
        tick();
        chk("add_accept", {31'd0, acc0}, 32'd1);
        REQ0_VALID = 0;
        chk("add_result", RSP0_OUT, 32'd12);
        tick();
        tick();

        // Tie after reset: requester 0 first (9-4), then requester 1 (3+3).
        reset_tick();
        REQ0_A = 32'd9; REQ0_B = 32'd4; REQ0_CTL = 5'd1; REQ0_VALID = 1;
        REQ1_A = 32'd3; REQ1_B = 32'd3; REQ1_CTL = 5'd0; REQ1_VALID = 1;
        RSP0_READY = 1; RSP1_READY = 1;
        tick();
        chk("tie_first_is_0", {31'd0, acc0}, 32'd1);
        REQ0_VALID = 0;
        chk("tie_rsp0", RSP0_OUT, 32'd5);
        tick();
        tick();
        chk("tie_second_is_1", {31'd0, acc1}, 32'd1);
        REQ1_VALID = 0;
        chk("tie_rsp1", RSP1_OUT, 32'd6);
        tick();

        // Round-robin fairness: both valid for 6 operations.
        grant_log.delete();
        REQ0_A = $urandom; REQ0_B = $urandom; REQ0_CTL = 5'($urandom_range(0, 1));
        REQ1_A = $urandom; REQ1_B = $urandom; REQ1_CTL = 5'($urandom_range(0, 1));
        REQ0_VALID = 1; REQ1_VALID = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (acc0) begin
                REQ0_A = $urandom; REQ0_B = $urandom; REQ0_CTL = 5'($urandom_range(0, 1));
            end
            if (acc1) begin
                REQ1_A = $urandom; REQ1_B = $urandom; REQ1_CTL = 5'($urandom_range(0, 1));
            end
        end
        REQ0_VALID = 0; REQ1_VALID = 0;
        chk("rr_count", grant_log.size(), 32'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk("rr_order", {31'd0, grant_log[k]}, k % 2);

        // Response backpressure on port 1 with RES = 0xFF, port 0 waiting.
        REQ1_A = 32'hF0; REQ1_B = 32'h0F; REQ1_CTL = 5'd0; REQ1_VALID = 1; RSP1_READY = 0;
        tick();
        REQ1_VALID = 0;
        REQ0_A = 32'd1; REQ0_B = 32'd2; REQ0_CTL = 5'd0; REQ0_VALID = 1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_hold_out", RSP1_OUT, 32'h0000_00FF);
            tick();
        end
        RSP1_READY = 1;
        tick();
        tick();
        chk("bp_then_req0", {31'd0, acc0}, 32'd1);
        REQ0_VALID = 0;
        tick();

        // Reset during RESP discards the held result.
        REQ0_A = 32'd10; REQ0_B = 32'd1; REQ0_CTL = 5'd1; REQ0_VALID = 1; RSP0_READY = 0;
        tick();
        REQ0_VALID = 0;
        tick();
        reset_tick();
        chk("mid_reset_busy", {31'd0, BUSY}, 32'd0);
        chk("mid_reset_rsp0", {31'd0, RSP0_VALID}, 32'd0);
        RSP0_READY = 1;
        REQ0_A = 32'd20; REQ0_B = 32'd2; REQ0_CTL = 5'd0; REQ0_VALID = 1;
        REQ1_A = 32'd7;  REQ1_B = 32'd7; REQ1_CTL = 5'd1; REQ1_VALID = 1;
        tick();
        chk("post_reset_tie", {31'd0, acc0}, 32'd1);
        REQ0_VALID = 0;
        tick();
        tick();
        REQ1_VALID = 0;
        tick();

        // Idle drive: no requests for 3 cycles.
        for (int k = 0; k < 3; k++) tick();
        chk("idle_sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter that time-shares a single combinational ALU instance between two requesters, for example the execute stage and a multi-cycle sequencer. Each requester presents operands A/B and a CTL opcode over a valid/ready request channel. The arbiter grants one requester round-robin and drives the shared ALU. It then captures the result into a register and returns it over that requester's valid/ready response channel. Only one operation is in flight at a time.

## Interface
- BITS, 32, operand/result width; must match the shared ALU.
- CBITS, 5, control-field width; must match the shared ALU.

- CLK  in  1  single clock; all state updates on rising edge.
- RESET_N  in  1  reset; synchronous, active-low.
- REQ0_VALID  in  1  requester 0 has an operation.
- REQ0_READY  out  1  requester 0 operation accepted this cycle.
- REQ0_A, REQ0_B  in  BITS  requester 0 operands.
- REQ0_CTL  in  CBITS  requester 0 opcode, passed through uninterpreted.
- RSP0_VALID  out  1  result for requester 0 available.
- RSP0_READY  in  1  requester 0 takes the result.
- RSP0_OUT  out  BITS  result for requester 0.
- REQ1_*, RSP1_*  same as port 0, for requester 1.
- ALU_A, ALU_B  out  BITS  operands to the shared ALU.
- ALU_CTL  out  CBITS  opcode to the shared ALU.
- ALU_OUT  in  BITS  combinational ALU result.
- BUSY  out  1  a result is held awaiting acceptance.

## Operation
- Two states: IDLE and RESP.
- Registered state: the state itself, OWNER (1 bit, requester holding the result), LAST (1 bit, last requester granted), RES (BITS).
- **IDLE, grant selection:**
  - Only REQ0_VALID high: grant 0.
  - Only REQ1_VALID high: grant 1.
  - Both high: grant the requester not equal to LAST.
  - Neither high: no grant.
- **IDLE, outputs:**
  - REQg_READY = 1 for the granted requester only. The other READY is 0.
  - ALU_A/ALU_B/ALU_CTL are driven combinationally from the granted requester's fields.
  - With no grant, ALU_A, ALU_B and ALU_CTL are all 0.
- **IDLE, on accept** (REQg_VALID and REQg_READY):
  - RES <= ALU_OUT.
  - OWNER <= g.
  - LAST <= g.
  - State -> RESP.
- **RESP:**
  - Both REQ*_READY = 0. ALU inputs are 0.
  - RSPx_VALID = 1 where x = OWNER. The other RSP_VALID is 0.
  - Both RSP*_OUT = RES. Non-owner value is don't-care to consumers.
  - When RSP(OWNER)_READY = 1, state -> IDLE.
  - RSP_READY of the non-owner is ignored.
- BUSY = 1 exactly when the state is RESP.
- The arbiter does no arithmetic and no width change. CTL values outside the ALU's decode return whatever the ALU produces (X in simulation). That X is forwarded unmodified.
- **Reset** (RESET_N = 0 at a rising edge):
  - State = IDLE, LAST = 1 (so requester 0 wins the first tie), OWNER = 0, RES = 0.
  - All READY/VALID outputs = 0 and BUSY = 0 in the cycle after reset.
  - Reset during RESP discards the held result. No response is delivered.
- Requester obligations: hold A/B/CTL stable while VALID is high and not yet accepted. VALID must not drop before accept.

## Timing
- **Request accept:** cycle N, combinational READY in the same cycle as VALID when granted.
- **Result valid:** RSP valid from cycle N+1, held with a stable value until RSP_READY is sampled high.
- **Minimum issue interval:** 2 cycles per operation (accept, then response cycle). No accept occurs in a cycle where RSP is accepted; the next accept is possible the cycle after.
- **READY path:** READY depends combinationally on VALID (grant logic). Neither READY depends on RSP_READY.
- **ALU path:** the combinational ALU path sits between REQ fields and RES within one cycle.
- **Starvation bound:** a requester holding VALID is granted within 2 operations.

## Test plan
- **Single ADD:** bench ALU with CMD_ADD=5'd0, CMD_SUB=5'd1; REQ0 A=5, B=7, CTL=0, RSP0_READY=1 -> REQ0_READY=1 cycle N; RSP0_VALID=1, RSP0_OUT=12 in cycle N+1; BUSY low again at N+2.
- **Tie after reset:** both VALID, REQ0 {9,4,SUB}, REQ1 {3,3,ADD} -> requester 0 granted first, RSP0_OUT=5. Requester 1 granted next IDLE cycle, RSP1_OUT=6. LAST=1 afterward.
- **Round-robin fairness:** both VALID continuously for 6 operations -> grant order 0,1,0,1,0,1; each RSP matches its operands.
- **Response backpressure:** RSP1_READY held 0 for 4 cycles with RES=0x0000_00FF -> RSP1_VALID and RSP1_OUT stable all 4 cycles. Both REQ_READY stay 0 and the pending REQ0 is not accepted. Release -> IDLE next cycle, REQ0 accepted.
- **Reset mid-operation:** RESET_N low during RESP -> next cycle RSP*_VALID=0, BUSY=0, state IDLE. A subsequent tie grants requester 0.
- **Idle drive:** no VALID for 3 cycles -> ALU_A=ALU_B=0, ALU_CTL=0, all READY/VALID 0, no state change.
